// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the FSM encoding and the carry-out recovery used around adder_32.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // adder_32 has no carry port; the top carry follows from the MSBs and sum.
  function automatic logic carry_out(input logic a_msb, input logic b_msb,
                                     input logic sum_msb);
    return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
  endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit gate-level ripple-carry adder; combinational, no backpressure.
// v flags signed overflow (carry into MSB differs from carry out of MSB).
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        v
);

  logic [32:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
  end

  assign v = c[32] ^ c[31];

endmodule

// File: rtl/mul_seq_32.sv
// Unsigned 32x32->64 shift-add multiplier, one multiplier bit per cycle; 33-cycle latency,
// start ignored while busy. MUL_EARLY_EXIT_EN: finish early once remaining multiplier bits are zero.
module mul_seq_32
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  if (WIDTH != MUL_WIDTH) begin : g_bad_width
    $error("mul_seq_32: WIDTH must be %0d to match adder_32", MUL_WIDTH);
  end
  if (CNT_W < $clog2(WIDTH + 1)) begin : g_bad_cnt
    $error("mul_seq_32: CNT_W too narrow for WIDTH");
  end

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   sum;
  logic               v_unused;
  logic               cout;
  logic               accept;
  logic               last_iter;

  assign b_sel = acc_lo[0] ? mcand : '0;

  adder_32 u_add (
    .a   (acc_hi),
    .b   (b_sel),
    .cin (1'b0),
    .sum (sum),
    .v   (v_unused)
  );

  assign cout      = carry_out(acc_hi[WIDTH-1], b_sel[WIDTH-1], sum[WIDTH-1]);
  assign accept    = start & ~abort;
  assign last_iter = (cnt == CNT_W'(MUL_ITERS - 1));
  assign product   = {acc_hi, acc_lo};

`ifdef MUL_EARLY_EXIT_EN
  // Low (32-cnt) bits of acc_lo are the multiplier bits not yet consumed.
  logic [WIDTH-1:0]   rest_bits;
  logic               rest_zero;
  logic [CNT_W-1:0]   shamt;
  logic [2*WIDTH-1:0] shifted;

  assign rest_bits = acc_lo << cnt;
  assign rest_zero = (rest_bits == '0);
  assign shamt     = CNT_W'(MUL_ITERS) - cnt;
  assign shifted   = {acc_hi, acc_lo} >> shamt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand  <= op_a;
            acc_hi <= '0;
            acc_lo <= op_b;
            cnt    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`ifdef MUL_EARLY_EXIT_EN
          else if (rest_zero) begin
            {acc_hi, acc_lo} <= shifted;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
          else begin
            acc_hi <= {cout, sum[WIDTH-1:1]};
            acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: expected product and done cycle queued at start,
// checked when done pulses; covers back-to-back, abort and async reset.
module tb_mul_seq_32;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  mul_seq_32 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycles from the cycle start is driven to the cycle done is seen.
  function automatic int exp_lat(input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return (EARLY && (n + 2 < 33)) ? n + 2 : 33;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_pulse_width", 64'(prev_done), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", product, e.prod);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_done = done;
  end

  task automatic wait_drain(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    int   nb;
    lat = exp_lat(b);
    @(negedge clk);
    op_a = a;
    op_b = b;
    start = 1'b1;
    e.prod = 64'(a) * 64'(b);
    e.cyc  = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op_a = ~a;
    op_b = ~b;
    nb = busy ? 1 : 0;
    for (int i = 2; i < lat; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("busy_cycles", 64'(nb), 64'(lat - 1));
    @(negedge clk);
    #1;
    chk("busy_at_done", 64'(busy), 64'd0);
    wait_drain(100);
    repeat (3) @(negedge clk);
    chk("product_hold", product, e.prod);
  endtask

  logic [31:0] ta[7] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF,
                         32'h0001_2345, 32'h0000_0000, 32'h8000_0000};
  logic [31:0] tb[7] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001,
                         32'h0000_0000, 32'h0000_ABCD, 32'hFFFF_FFFF};
  logic [31:0] ba[3] = '{32'h0000_0002, 32'h8000_0000, 32'h1234_5678};
  logic [31:0] bb[3] = '{32'h0000_0007, 32'h0000_0002, 32'h9ABC_DEF0};

  initial begin
    exp_t e;
    int   t;

    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_one(ta[i], tb[i]);

    // start held high: later start pulses during RUN must be ignored
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    for (int i = 0; i < 3; i++) begin
      op_a = ba[i];
      op_b = bb[i];
      e.prod = 64'(ba[i]) * 64'(bb[i]);
      t = t + exp_lat(bb[i]);
      e.cyc = t;
      sb.push_back(e);
      @(negedge clk);
      if (i < 2) begin
        op_a = 32'h5555_5555;
        op_b = 32'hAAAA_AAAA;
        while (cyc < t) @(negedge clk);
      end
    end
    start = 1'b0;
    wait_drain(150);

    // abort mid-run; start coinciding with abort is dropped
    @(negedge clk);
    op_a = 32'hFFFF_FFFF;
    op_b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);
    @(negedge clk);
    chk("abort_wins_start", 64'(busy), 64'd0);
    abort = 1'b0;
    op_a = 32'd6;
    op_b = 32'd7;
    e.prod = 64'd42;
    e.cyc = cyc + exp_lat(32'd7);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_drain(100);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    op_a = 32'h1234_5678;
    op_b = 32'h8000_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_done", 64'(done), 64'd0);
    chk("async_reset_product", product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_product", product, 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
